// File: rtl/pixel_stream_loader.sv
// Stream loader: accepts one RGB888 frame, converts each pixel to 8-bit luma and writes it in raster order.
// Optional LOADER_CHECKSUM_EN adds io_checksum, the mod-2^16 sum of the luma bytes written this frame.
module pixel_stream_loader #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18,
    parameter int COEF_R = 77,
    parameter int COEF_G = 150,
    parameter int COEF_B = 29
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_load_start,
    output logic              io_load_done,
    output logic              io_busy,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [23:0]       io_in_rgb,
    input  logic              io_in_last,
    output logic              io_mem_wen,
    output logic [ADDR_W-1:0] io_mem_addr,
    output logic [7:0]        io_mem_wdata,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0]       io_checksum,
`endif
    output logic              io_err_frame
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int unsigned NUM_PIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);
    localparam logic [15:0] CR = 16'(COEF_R);
    localparam logic [15:0] CG = 16'(COEF_G);
    localparam logic [15:0] CB = 16'(COEF_B);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pix_idx;
    logic              accept;
    logic              at_last_idx;
    logic              frame_end;

    logic              s1_valid;
    logic [15:0]       s1_prod_r;
    logic [15:0]       s1_prod_g;
    logic [15:0]       s1_prod_b;
    logic [ADDR_W-1:0] s1_addr;
    logic [16:0]       luma_sum;
    logic              luma_sum_unused;

    assign io_in_ready  = (state == LOAD);
    assign io_busy      = (state == LOAD) || (state == DRAIN);
    assign io_load_done = (state == DONE);

    assign accept      = io_in_valid & io_in_ready;
    assign at_last_idx = (pix_idx == LAST_IDX);
    assign frame_end   = accept & (io_in_last | at_last_idx);

    // Weights sum to 256, so the rounded sum of three 8-bit products never exceeds 16 bits.
    assign luma_sum = {1'b0, s1_prod_r} + {1'b0, s1_prod_g} + {1'b0, s1_prod_b} + 17'd128;
    assign luma_sum_unused = ^{luma_sum[16], luma_sum[7:0]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            pix_idx      <= '0;
            io_err_frame <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_load_start) begin
                        state        <= LOAD;
                        pix_idx      <= '0;
                        io_err_frame <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        pix_idx <= pix_idx + ADDR_W'(1);
                    end
                    if (frame_end) begin
                        state <= DRAIN;
                        // Error when last and the final index disagree: early last, or missing last.
                        io_err_frame <= io_in_last ^ at_last_idx;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !io_mem_wen) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!io_load_start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_prod_r <= '0;
            s1_prod_g <= '0;
            s1_prod_b <= '0;
            s1_addr   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod_r <= 16'(io_in_rgb[23:16]) * CR;
                s1_prod_g <= 16'(io_in_rgb[15:8]) * CG;
                s1_prod_b <= 16'(io_in_rgb[7:0]) * CB;
                s1_addr   <= pix_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            io_mem_wen   <= 1'b0;
            io_mem_wdata <= '0;
            io_mem_addr  <= '0;
        end else begin
            io_mem_wen <= s1_valid;
            if (s1_valid) begin
                io_mem_wdata <= luma_sum[15:8];
                io_mem_addr  <= s1_addr;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Pipeline is always empty in IDLE, so clearing on start never races an accumulate.
    always_ff @(posedge clock) begin
        if (!reset) begin
            io_checksum <= '0;
        end else if (state == IDLE && io_load_start) begin
            io_checksum <= '0;
        end else if (io_mem_wen) begin
            io_checksum <= io_checksum + 16'(io_mem_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_pixel_stream_loader.sv
// Directed bench for pixel_stream_loader on a 4x4 frame; writes are captured by a negedge monitor.
// Build with LOADER_CHECKSUM_EN defined to also cover io_checksum.
module tb_pixel_stream_loader;

    localparam int ADDR_W = 18;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_load_start;
    logic              io_load_done;
    logic              io_busy;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [23:0]       io_in_rgb;
    logic              io_in_last;
    logic              io_mem_wen;
    logic [ADDR_W-1:0] io_mem_addr;
    logic [7:0]        io_mem_wdata;
    logic              io_err_frame;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       io_checksum;
`endif

    pixel_stream_loader #(
        .IMG_W (4),
        .IMG_H (4),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_load_start(io_load_start),
        .io_load_done (io_load_done),
        .io_busy      (io_busy),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_rgb    (io_in_rgb),
        .io_in_last   (io_in_last),
        .io_mem_wen   (io_mem_wen),
        .io_mem_addr  (io_mem_addr),
        .io_mem_wdata (io_mem_wdata),
`ifdef LOADER_CHECKSUM_EN
        .io_checksum  (io_checksum),
`endif
        .io_err_frame (io_err_frame)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    logic [ADDR_W-1:0] wr_addr [256];
    logic [7:0]        wr_data [256];
    int                wr_cyc  [256];
    int                wr_cnt = 0;

    always @(negedge clock) begin
        if (io_mem_wen === 1'b1 && wr_cnt < 256) begin
            wr_addr[wr_cnt] <= io_mem_addr;
            wr_data[wr_cnt] <= io_mem_wdata;
            wr_cyc[wr_cnt]  <= cyc;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    logic [7:0] exp_data [64];
    int exp_n     = 0;
    int base      = 0;
    int first_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [23:0] rgb, input logic last, input logic [7:0] exp_l, input int gap);
        int  budget;
        logic acc;
        budget = 0;
        acc    = 1'b0;
        io_in_valid = 1'b0;
        repeat (gap) tick();
        io_in_valid = 1'b1;
        io_in_rgb   = rgb;
        io_in_last  = last;
        while (!acc && budget < 50) begin
            acc = io_in_ready;
            if (acc && exp_n == 0) first_acc = cyc;
            tick();
            budget++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
        if (exp_n < 64) exp_data[exp_n] = exp_l;
        exp_n++;
    endtask

    task automatic start_frame();
        base  = wr_cnt;
        exp_n = 0;
        io_load_start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 0;
        while (io_load_done !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        chk({tag, "_done"}, 32'(io_load_done), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int n);
        int got;
        int bad_a;
        int bad_d;
        got   = wr_cnt - base;
        bad_a = 0;
        bad_d = 0;
        chk({tag, "_wr_count"}, 32'(got), 32'(n));
        for (int i = 0; i < n && i < got; i++) begin
            if (wr_addr[base + i] !== ADDR_W'(i)) bad_a++;
            if (wr_data[base + i] !== exp_data[i]) bad_d++;
        end
        chk({tag, "_addr_errs"}, 32'(bad_a), 32'd0);
        chk({tag, "_data_errs"}, 32'(bad_d), 32'd0);
    endtask

    task automatic end_frame(input string tag);
        io_load_start = 1'b0;
        tick();
        chk({tag, "_done_drop"}, 32'(io_load_done), 32'd0);
    endtask

    // Expected luma = (77R + 150G + 29B + 128) >> 8
    logic [23:0] pat_rgb [5];
    logic [7:0]  pat_lum [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_rgb[0] = 24'h000000; pat_lum[0] = 8'd0;
        pat_rgb[1] = 24'hFFFFFF; pat_lum[1] = 8'd255;
        pat_rgb[2] = 24'h0A141E; pat_lum[2] = 8'd18;
        pat_rgb[3] = 24'h00FF00; pat_lum[3] = 8'd149;
        pat_rgb[4] = 24'h0000FF; pat_lum[4] = 8'd29;

        // Reset held with valid and start high.
        reset         = 1'b0;
        io_load_start = 1'b1;
        io_in_valid   = 1'b1;
        io_in_rgb     = 24'hFF0000;
        io_in_last    = 1'b0;
        repeat (5) tick();
        chk("rst_ready", 32'(io_in_ready), 32'd0);
        chk("rst_wen",   32'(io_mem_wen),  32'd0);
        chk("rst_done",  32'(io_load_done), 32'd0);
        chk("rst_busy",  32'(io_busy),     32'd0);
        chk("rst_err",   32'(io_err_frame), 32'd0);
        io_in_valid   = 1'b0;
        io_load_start = 1'b0;
        reset         = 1'b1;
        tick();
        chk("idle_ready", 32'(io_in_ready), 32'd0);

        // Back-to-back red frame, last on pixel 15.
        start_frame();
        chk("t2_busy",  32'(io_busy),     32'd1);
        chk("t2_ready", 32'(io_in_ready), 32'd1);
        for (int i = 0; i < 16; i++) send(24'hFF0000, (i == 15), 8'h4D, 0);
        wait_done("t2");
        chk("t2_err",   32'(io_err_frame), 32'd0);
        chk("t2_busy_done", 32'(io_busy), 32'd0);
        chk("t2_ready_done", 32'(io_in_ready), 32'd0);
        check_frame("t2", 16);
        chk("t2_latency", 32'(wr_cyc[base] - first_acc), 32'd2);
        chk("t2_last_addr", 32'(wr_addr[base + 15]), 32'd15);
        end_frame("t2");

        // Random valid gaps with mixed colours.
        start_frame();
        for (int i = 0; i < 16; i++)
            send(pat_rgb[i % 5], (i == 15), pat_lum[i % 5], int'($urandom_range(0, 2)));
        wait_done("t3");
        chk("t3_err", 32'(io_err_frame), 32'd0);
        check_frame("t3", 16);
        end_frame("t3");

        // Early last on pixel 9.
        start_frame();
        for (int i = 0; i < 10; i++) send(24'hFFFFFF, (i == 9), 8'd255, 0);
        chk("t4a_ready_after_last", 32'(io_in_ready), 32'd0);
        wait_done("t4a");
        chk("t4a_err", 32'(io_err_frame), 32'd1);
        check_frame("t4a", 10);
        end_frame("t4a");

        // Next start clears the error; this frame has no last on pixel 15.
        start_frame();
        chk("t4b_err_cleared", 32'(io_err_frame), 32'd0);
        for (int i = 0; i < 16; i++) send(24'h0A141E, 1'b0, 8'd18, 0);
        chk("t4b_ready_after_15", 32'(io_in_ready), 32'd0);
        io_in_valid = 1'b1;
        repeat (3) tick();
        io_in_valid = 1'b0;
        wait_done("t4b");
        chk("t4b_err", 32'(io_err_frame), 32'd1);
        check_frame("t4b", 16);
        end_frame("t4b");

        // Reset pulsed mid-frame after pixel 7.
        start_frame();
        for (int i = 0; i < 8; i++) send(24'hFFFFFF, 1'b0, 8'd255, 0);
        reset         = 1'b0;
        io_load_start = 1'b0;
        tick();
        reset = 1'b1;
        base  = wr_cnt;
        chk("t5_wen_after_rst",  32'(io_mem_wen), 32'd0);
        chk("t5_busy_after_rst", 32'(io_busy),    32'd0);
        repeat (4) tick();
        chk("t5_no_writes", 32'(wr_cnt - base), 32'd0);
        start_frame();
        for (int i = 0; i < 16; i++) send(pat_rgb[i % 5], (i == 15), pat_lum[i % 5], 0);
        wait_done("t5");
        chk("t5_err", 32'(io_err_frame), 32'd0);
        check_frame("t5", 16);
        chk("t5_first_addr", 32'(wr_addr[base]), 32'd0);
        end_frame("t5");

`ifdef LOADER_CHECKSUM_EN
        start_frame();
        for (int i = 0; i < 16; i++) send(24'hFFFFFF, (i == 15), 8'd255, 0);
        wait_done("t6");
        chk("t6_checksum", 32'(io_checksum), 32'h0FF0);
        check_frame("t6", 16);
        end_frame("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
